// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: waits for a stable PLL lock, then emits 64-slot
// stereo frames (MSB first, one-BCLK delay) from a single holding register.
// bclk, lrclk, sdata, running, underrun and in_ready are all registered.
module i2s_tx_serializer #(
   parameter int DIV       = 15,
   parameter int LOCK_WAIT = 1024,
   parameter int DW        = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          locked,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_left,
   input  logic [DW-1:0] in_right,
   output logic          bclk,
   output logic          lrclk,
   output logic          sdata,
   output logic          running,
   output logic          underrun
);

   localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
   localparam logic [7:0]  HALF_CNT = 8'(DIV / 2);
   localparam logic [15:0] LW_LAST  = 16'(LOCK_WAIT - 1);
   localparam logic [4:0]  DW_POS   = 5'(DW);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          lock_meta_q, lock_s_q;
   logic [15:0]   stab_q, stab_d;
   logic [7:0]    div_q, div_d;
   logic [5:0]    b_q, b_d;
   logic          hold_full_q, hold_full_d;
   logic [DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DW-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
   logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
   logic          running_q, running_d, underrun_q, underrun_d;
   logic          in_ready_q, in_ready_d;
   logic          accept_s, frame_start_s;
   logic [4:0]    pos_s;

   // Bit DW-pos of a word, i.e. MSB at slot position 1.
   function automatic logic pick_bit(input logic [DW-1:0] word, input logic [4:0] pos);
      logic [DW-1:0] shifted;
      shifted = word << (pos - 5'd1);
      return shifted[DW-1];
   endfunction

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= locked;
         lock_s_q    <= lock_meta_q;
      end
   end

   // State, counters, holding/active registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_LOCK;
         stab_q      <= 16'd0;
         div_q       <= 8'd0;
         b_q         <= 6'd0;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         act_l_q     <= '0;
         act_r_q     <= '0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         running_q   <= 1'b0;
         underrun_q  <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         stab_q      <= stab_d;
         div_q       <= div_d;
         b_q         <= b_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         act_l_q     <= act_l_d;
         act_r_q     <= act_r_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         running_q   <= running_d;
         underrun_q  <= underrun_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state logic; outputs are derived from the next-state counters so
   // that lrclk/sdata/b change together with the falling edge of bclk.
   always_comb begin
      state_d       = state_q;
      stab_d        = stab_q;
      div_d         = div_q;
      b_d           = b_q;
      hold_full_d   = hold_full_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      act_l_d       = act_l_q;
      act_r_d       = act_r_q;
      bclk_d        = 1'b0;
      lrclk_d       = 1'b0;
      sdata_d       = 1'b0;
      running_d     = 1'b0;
      underrun_d    = 1'b0;
      in_ready_d    = 1'b0;
      frame_start_s = 1'b0;
      accept_s      = in_valid & in_ready_q;
      pos_s         = 5'd0;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = STABLE;
               stab_d  = 16'd0;
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         STABLE: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
            end else if (stab_q == LW_LAST) begin
               state_d       = RUN;
               div_d         = 8'd0;
               b_d           = 6'd0;
               frame_start_s = 1'b1;
            end else begin
               stab_d = stab_q + 16'd1;
            end
         end
         RUN: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
            end else begin
               if (div_q == DIV_LAST) begin
                  div_d = 8'd0;
               end else begin
                  div_d = div_q + 8'd1;
               end
               if (div_d == HALF_CNT) begin
                  b_d = b_q + 6'd1;
                  if (b_d == 6'd0) begin
                     frame_start_s = 1'b1;
                  end else begin
                     frame_start_s = 1'b0;
                  end
               end else begin
                  b_d = b_q;
               end
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      // Frame start consumes the holding register as it was before this clk.
      if (frame_start_s) begin
         if (hold_full_q) begin
            act_l_d = hold_l_q;
            act_r_d = hold_r_q;
         end else begin
            act_l_d    = '0;
            act_r_d    = '0;
            underrun_d = 1'b1;
         end
         hold_full_d = 1'b0;
      end else begin
         hold_full_d = hold_full_q;
      end

      if (accept_s) begin
         hold_l_d    = in_left;
         hold_r_d    = in_right;
         hold_full_d = 1'b1;
      end else begin
         hold_full_d = hold_full_d;
      end

      // Losing lock flushes everything so a relock starts a clean frame.
      if (state_d == WAIT_LOCK) begin
         hold_full_d = 1'b0;
         hold_l_d    = '0;
         hold_r_d    = '0;
         act_l_d     = '0;
         act_r_d     = '0;
         div_d       = 8'd0;
         b_d         = 6'd0;
         underrun_d  = 1'b0;
      end else begin
         in_ready_d = ~hold_full_d;
      end

      if (state_d == RUN) begin
         pos_s     = b_d[4:0];
         running_d = 1'b1;
         bclk_d    = (div_d < HALF_CNT);
         lrclk_d   = b_d[5];
         if ((pos_s != 5'd0) && (pos_s <= DW_POS)) begin
            sdata_d = b_d[5] ? pick_bit(act_r_d, pos_s) : pick_bit(act_l_d, pos_s);
         end else begin
            sdata_d = 1'b0;
         end
      end else begin
         running_d = 1'b0;
      end
   end

   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign running  = running_q;
   assign underrun = underrun_q;
   assign in_ready = in_ready_q;

endmodule
